aes_decrypt_iter: RTL and testbench
===================================

// Module: aes_decrypt_iter
// PURPOSE
//  Iterative AES inverse cipher (FIPS-197 §5.3): one inverse round per clk, 128/192/256-bit keys.
//  Receive-side counterpart of the encrypt round iterator; consumes the same packed expanded-key bus.
//  Sits between the ciphertext source and the plaintext consumer/display.
//  Inverse S-box lookups use 16 instances of the combinational inv_sbox (8b->8b); that module is not part of this block.
// PARAMETERS
//  KEYW    1920  width of expanded-key bus (15 round keys x 128)
//  DATAW   128   AES block width; fixed, not overridable in practice
// PORTS
//  clk     in   1     rising-edge clock
//  rst_n   in   1     asynchronous active-low reset
//  start   in   1     request a decryption; sampled only when busy=0
//  switch  in   2     key size: 00=128 (nr=10), 01=192 (nr=12), 10/11=256 (nr=14)
//  in      in   128   ciphertext; byte0 = in[127:120], column-major per FIPS-197
//  key_d   in   1920  round keys; rk[i] = key_d[i*128 +: 128], rk[0] = cipher key words 0-3
//  out     out  128   plaintext, registered, same byte order as in
//  busy    out  1     high while a block is in flight
//  done    out  1     one-cycle pulse: out holds new plaintext
// BEHAVIOUR
//  Reset: FSM=IDLE, state reg=0, round ctr=0, out=0, busy=0, done=0.
//  FSM: IDLE -> INIT -> ROUND (repeats) -> LAST -> IDLE.
//  Capture edge (busy=0, start=1): latch nr from switch, latch in; busy=1 after the edge.
//   switch and in are sampled only at this edge.
//  INIT edge: state <= in_latched ^ rk[nr]; r <= nr-1.
//  ROUND edge (r>=1):
//   state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r]); r <= r-1.
//   Exit to LAST when r==1 at this edge.
//  LAST edge: out <= InvSubBytes(InvShiftRows(state)) ^ rk[0];
//   done=1 and busy=0 for the following cycle only.
//  Latency: done high in the cycle following capture edge + (nr+1) edges:
//   11 / 13 / 15 clks for nr=10/12/14.
//  key_d must be held stable from capture edge until done; it is not latched.
//  start while busy=1: ignored, no queuing, no effect on the block in flight.
//  start during the done cycle: accepted (busy=0 then); back-to-back with no gap.
//  out changes only at the LAST edge; held between blocks and across ignored starts.
//  switch change mid-block: no effect; nr is latched.
//  rst_n low at any time: immediate return to reset values; the in-flight block is discarded, no done.
//  InvMixColumns: GF(2^8) mod x^8+x^4+x^3+x+1, coefficients {0e,0b,0d,09}.
//  xtime chains are combinational within the round cycle.
// TESTING
//  Bench packs key_d from a reference key expansion.
//  AES-128 (FIPS-197 C.1): key 000102..0f, in=69c4e0d86a7b0430d8cdb78070b4c55a
//   -> out=00112233445566778899aabbccddeeff, done 11 clks after start.
//  AES-192 (C.2): key 000102..17, in=dda97ca4864cdfe06eaf70a0ec0d7191, switch=01
//   -> same plaintext, done at 13 clks.
//  AES-256 (C.3): key 000102..1f, in=8ea2b7ca516745bfeafc49904b496089, switch=10, then 11
//   -> same plaintext at 15 clks, both runs.
//  start pulsed at clk 4 of a busy block with different in/switch
//   -> first result unchanged, single done, busy continuous.
//  rst_n low at clk 6 of an AES-128 block
//   -> out=0, busy=0 immediately; done never pulses.
//  New start asserted in the done cycle
//   -> second block completes 11 clks later; out holds first result until then.

Source files
------------

// File: rtl/aes_decrypt_iter_if.sv
// rtl/aes_decrypt_iter_if.sv - block/key/handshake bundle for the iterative AES decryptor
//
// Purpose : groups the ciphertext request, expanded-key bus and plaintext result.
// Signals : start  - request a decryption (master -> slave)
//           switch - key size select 00=128, 01=192, 1x=256
//           in     - ciphertext block, byte0 in bits [127:120]
//           key_d  - packed round keys, rk[i] = key_d[i*128 +: 128]
//           out    - registered plaintext
//           busy   - block in flight
//           done   - one-cycle pulse when out is updated
interface aes_decrypt_iter_if #(
    parameter int KEYW  = 1920,
    parameter int DATAW = 128
);
    logic             start;
    logic [1:0]       switch;
    logic [DATAW-1:0] in;
    logic [KEYW-1:0]  key_d;
    logic [DATAW-1:0] out;
    logic             busy;
    logic             done;

    modport master (output start, switch, in, key_d, input out, busy, done);
    modport slave  (input start, switch, in, key_d, output out, busy, done);
endinterface

// File: rtl/aes_decrypt_iter.sv
// rtl/aes_decrypt_iter.sv - iterative AES inverse cipher, one inverse round per clock
//
// Purpose : decrypts one 128-bit block with a 128/192/256-bit key using a
//           pre-expanded key bus; IDLE -> INIT -> ROUND.. -> LAST -> IDLE.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - aes_decrypt_iter_if slave (start/switch/in/key_d in, out/busy/done out)
// inv_sbox: 8-bit inverse S-box lookup, 16 copies instantiated by the decryptor.
module inv_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    assign y_o = INV_SBOX[a_i];
endmodule

module aes_decrypt_iter #(
    parameter int KEYW  = 1920,
    parameter int DATAW = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    aes_decrypt_iter_if.slave   bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] INIT  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] LAST  = 2'd3;
    localparam int         KBW   = $clog2(KEYW);

    logic [1:0]       fsm_q, fsm_d;
    logic [DATAW-1:0] st_q, st_d;
    logic [DATAW-1:0] out_q, out_d;
    logic [3:0]       r_q, r_d;
    logic [3:0]       nr_q, nr_d;
    logic             done_q, done_d;

    logic [3:0]       key_sel;
    logic [KBW-1:0]   rk_base;
    logic [DATAW-1:0] rk, shifted, subbed, mixed;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // s'[row][col] = s[row][(col - row) mod 4]
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        logic [7:0]   m9 [4], mb [4], md [4], me [4];
        logic [7:0]   x2, x4, x8;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[127-8*(4*c+r) -: 8];
                x2    = xt(a[r]);
                x4    = xt(x2);
                x8    = xt(x4);
                m9[r] = x8 ^ a[r];
                mb[r] = x8 ^ x2 ^ a[r];
                md[r] = x8 ^ x4 ^ a[r];
                me[r] = x8 ^ x4 ^ x2;
            end
            o[127-8*(4*c+0) -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            o[127-8*(4*c+1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            o[127-8*(4*c+2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            o[127-8*(4*c+3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return o;
    endfunction

    // One shared round-key mux: rk[nr] at INIT, rk[0] at LAST, rk[r] otherwise.
    always_comb begin
        key_sel = r_q;
        if (fsm_q == INIT)      key_sel = nr_q;
        else if (fsm_q == LAST) key_sel = 4'd0;
    end
    assign rk_base = KBW'({key_sel, 7'd0});
    assign rk      = bus.key_d[rk_base +: DATAW];

    assign shifted = inv_shift_rows(st_q);
    for (genvar g = 0; g < 16; g++) begin : g_sbox
        inv_sbox u_inv_sbox (.a_i(shifted[127-8*g -: 8]), .y_o(subbed[127-8*g -: 8]));
    end
    assign mixed = inv_mix_columns(subbed ^ rk);

    always_comb begin
        fsm_d  = fsm_q;
        st_d   = st_q;
        r_d    = r_q;
        nr_d   = nr_q;
        out_d  = out_q;
        done_d = 1'b0;
        case (fsm_q)
            IDLE: if (bus.start) begin
                st_d  = bus.in;
                nr_d  = (bus.switch == 2'b00) ? 4'd10 : (bus.switch == 2'b01) ? 4'd12 : 4'd14;
                fsm_d = INIT;
            end
            INIT: begin
                st_d  = st_q ^ rk;
                r_d   = nr_q - 4'd1;
                fsm_d = ROUND;
            end
            ROUND: begin
                st_d = mixed;
                r_d  = r_q - 4'd1;
                if (r_q == 4'd1) fsm_d = LAST;
            end
            LAST: begin
                out_d  = subbed ^ rk;
                done_d = 1'b1;
                fsm_d  = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= IDLE;
            st_q   <= '0;
            r_q    <= '0;
            nr_q   <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            r_q    <= r_d;
            nr_q   <= nr_d;
            out_q  <= out_d;
            done_q <= done_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = (fsm_q != IDLE);
    assign bus.done = done_q;
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// tb/tb_aes_decrypt_iter.sv - self-checking bench for aes_decrypt_iter
module tb_aes_decrypt_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_decrypt_iter_if #(.KEYW(1920), .DATAW(128)) bus ();
    aes_decrypt_iter #(.KEYW(1920), .DATAW(128)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [255:0] key;
        int           nk;
        logic [1:0]   sw;
        logic [127:0] ct;
        logic [127:0] pt;
        int           lat;
    } vec_t;

    typedef struct {
        logic [127:0] pt;
        int           cyc;
    } exp_t;

    vec_t  vt [5];
    exp_t  sb [$];
    logic [7:0] fsb [256];
    int    cyc = 0;
    int    n_total = 0;
    int    n_pass = 0;
    int    ndone = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            exp_t e;
            ndone++;
            if (sb.size() == 0) check("unexpected_done", 1, 0);
            else begin
                e = sb.pop_front();
                check("plaintext", bus.out, e.pt);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {fsb[t[31:24]], fsb[t[23:16]], fsb[t[15:8]], fsb[t[7:0]]};
    endfunction

    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1919:0] kd = '0;
        int            nr = nk + 6;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) w[i] = key[255-32*i -: 32];
            else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xt(rc);
                end else if (nk > 6 && i % nk == 4) t = subw(t);
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int j = 0; j <= nr; j++) kd[j*128 +: 128] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
        return kd;
    endfunction

    task automatic drive(input vec_t v);
        exp_t e;
        bus.start  = 1'b1;
        bus.in     = v.ct;
        bus.switch = v.sw;
        bus.key_d  = expand(v.key, v.nk);
        e.pt  = v.pt;
        e.cyc = cyc + 1 + v.lat;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int budget, output int bc);
        bit ok = 1'b0;
        bc = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.busy) bc++;
            if (sb.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        int bc;
        int d0;
        bus.start = 1'b0; bus.switch = 2'b00; bus.in = '0; bus.key_d = '0;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00, b;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            fsb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end

        vt[0] = '{{128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 2'b00,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 11};
        vt[1] = '{{192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 2'b01,
                  128'hdda97ca4864cdfe06eaf70a0ec0d7191, 128'h00112233445566778899aabbccddeeff, 13};
        vt[2] = '{256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 2'b10,
                  128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff, 15};
        vt[3] = vt[2];
        vt[3].sw = 2'b11;
        vt[4] = '{{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 2'b00,
                  128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, 11};

        repeat (3) @(negedge clk);
        check("reset_out", bus.out, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            drive(vt[i]);
            wait_done(40, bc);
            check($sformatf("busy_cycles_v%0d", i), bc, vt[i].lat);
        end

        // start mid-block with a different block and key size must be ignored
        @(negedge clk); #1;
        drive(vt[0]);
        d0 = ndone;
        bc = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk); #1;
            if (k == 1) bus.start = 1'b0;
            if (k == 4) begin bus.start = 1'b1; bus.in = vt[2].ct; bus.switch = 2'b10; end
            if (k == 5) bus.start = 1'b0;
            if (bus.busy) bc++;
            if (sb.size() == 0) break;
        end
        check("ignored_start_busy", bc, 11);
        repeat (20) @(negedge clk);
        check("ignored_start_ndone", ndone - d0, 1);

        // reset in the middle of an AES-128 block
        @(negedge clk); #1;
        drive(vt[0]);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            bus.start = 1'b0;
        end
        check("pre_reset_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("midreset_out", bus.out, 0);
        check("midreset_busy", bus.busy, 0);
        check("midreset_done", bus.done, 0);
        sb.delete();
        d0 = ndone;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midreset_no_done", ndone - d0, 0);

        // back-to-back: second start in the done cycle of the first
        @(negedge clk); #1;
        drive(vt[4]);
        wait_done(40, bc);
        drive(vt[0]);
        @(negedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_out_hold", bus.out, vt[4].pt);
        check("b2b_busy", bus.busy, 1);
        wait_done(40, bc);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
